// File: rtl/alu_ctrl_stage.sv
// ALU control stage: decodes alu_op/funct/opcode to a 4-bit ALU control code and registers operands.
// Latency: exactly one clock from decode inputs to every output; no combinational input-to-output path.
// Backpressure: stall holds every output register (including illegal_count); flush inserts a bubble.
//
// Optional feature: define ALU_CTRL_NOR_EN to decode R-type funct 0x27 as NOR (1100);
// without it, funct 0x27 is treated as an illegal instruction.
//
// Ports:
//   clk, reset              single clock, synchronous active-high reset
//   id_valid                decode stage presents a real instruction
//   alu_op[1:0]             00 mem, 01 branch, 10 R-type, 11 immediate
//   funct[5:0], opcode[5:0] R-type function field / opcode used for alu_op=11
//   alu_src                 1 selects imm as operand b, 0 selects rt_data
//   rs_data, rt_data, imm   32-bit operands (imm already extended)
//   stall, flush            hold outputs / replace stage contents with a bubble
//   ex_valid, ex_control    registered valid and ALU control code
//   ex_a, ex_b              registered ALU operands
//   ex_illegal              registered undecodable-instruction flag
//   illegal_count[7:0]      saturating count of illegal instructions accepted

module alu_ctrl_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [1:0]  alu_op,
    input  logic [5:0]  funct,
    input  logic [5:0]  opcode,
    input  logic        alu_src,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic [31:0] imm,
    input  logic        stall,
    input  logic        flush,
    output logic        ex_valid,
    output logic [3:0]  ex_control,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic        ex_illegal,
    output logic [7:0]  illegal_count
);

    localparam logic [3:0] CTL_AND = 4'b0000;
    localparam logic [3:0] CTL_OR  = 4'b0001;
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_SUB = 4'b0110;
    localparam logic [3:0] CTL_SLT = 4'b0111;
`ifdef ALU_CTRL_NOR_EN
    localparam logic [3:0] CTL_NOR = 4'b1100;
`endif

    logic [3:0] dec_control;
    logic       dec_illegal;

    // Raw decode, before qualification by id_valid. Illegal decodes drive
    // CTL_AND (0000) so the ALU never sees an undefined code.
    always_comb begin
        dec_control = CTL_AND;
        dec_illegal = 1'b0;
        case (alu_op)
            2'b00: dec_control = CTL_ADD;
            2'b01: dec_control = CTL_SUB;
            2'b10: begin
                case (funct)
                    6'h20, 6'h21: dec_control = CTL_ADD;
                    6'h22, 6'h23: dec_control = CTL_SUB;
                    6'h24:        dec_control = CTL_AND;
                    6'h25:        dec_control = CTL_OR;
                    6'h2A:        dec_control = CTL_SLT;
`ifdef ALU_CTRL_NOR_EN
                    6'h27:        dec_control = CTL_NOR;
`endif
                    default:      dec_illegal = 1'b1;
                endcase
            end
            default: begin
                case (opcode)
                    6'h08:   dec_control = CTL_ADD;
                    6'h0C:   dec_control = CTL_AND;
                    6'h0D:   dec_control = CTL_OR;
                    6'h0A:   dec_control = CTL_SLT;
                    default: dec_illegal = 1'b1;
                endcase
            end
        endcase
    end

    // Priority per edge: reset, then flush, then stall (hold), then load.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid      <= 1'b0;
            ex_control    <= 4'b0000;
            ex_a          <= 32'd0;
            ex_b          <= 32'd0;
            ex_illegal    <= 1'b0;
            illegal_count <= 8'd0;
        end else if (flush) begin
            // Bubble: illegal_count is deliberately left untouched.
            ex_valid   <= 1'b0;
            ex_control <= 4'b0000;
            ex_a       <= 32'd0;
            ex_b       <= 32'd0;
            ex_illegal <= 1'b0;
        end else if (!stall) begin
            ex_valid   <= id_valid;
            ex_a       <= rs_data;
            ex_b       <= alu_src ? imm : rt_data;
            // A non-instruction slot carries no control code or illegal flag,
            // but its operands are still captured.
            ex_control <= id_valid ? dec_control : 4'b0000;
            ex_illegal <= id_valid & dec_illegal;
            if (id_valid && dec_illegal && (illegal_count != 8'hFF))
                illegal_count <= illegal_count + 8'd1;
        end
    end

endmodule
